// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the streaming population-count accumulator.
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } popcnt_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcnt_compress.sv
// Combinational bit-count compressor: a linear adder chain (Speed=0)
// or a balanced adder tree (Speed=1) reducing Width bits to a CntW-bit count.
module popcnt_compress
  import popcnt_pkg::*;
#(
  parameter int Width = 16,
  parameter int Speed = 1,
  localparam int CntW = cnt_width(Width)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  localparam int Levels = $clog2(Width);
  localparam int Pad    = 1 << Levels;

  function automatic logic [CntW-1:0] chain_count(input logic [Width-1:0] d);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < Width; i++) c = c + CntW'(d[i]);
    return c;
  endfunction

  // Pairwise reduction in place: after each pass node[i] holds the count of
  // a 2*step-bit group starting at bit i.
  function automatic logic [CntW-1:0] tree_count(input logic [Width-1:0] d);
    logic [CntW-1:0] node [Pad];
    logic [Pad-1:0]  d_pad;
    d_pad = Pad'(d);
    for (int i = 0; i < Pad; i++) node[i] = CntW'(d_pad[i]);
    for (int step = 1; step < Pad; step = step * 2) begin
      for (int i = 0; i < Pad; i = i + 2 * step) node[i] = node[i] + node[i + step];
    end
    return node[0];
  endfunction

  generate
    if (Speed == 0) begin : g_chain
      assign count_o = chain_count(data_i);
    end else begin : g_tree
      assign count_o = tree_count(data_i);
    end
  endgenerate

endmodule

// File: rtl/popcnt_stream_acc.sv
// Three-stage streaming popcount accumulator with per-frame totals.
// Define POPCNT_SATURATE_EN to clamp the accumulator instead of wrapping.
module popcnt_stream_acc
  import popcnt_pkg::*;
#(
  parameter int Width    = 16,
  parameter int AccWidth = 16,
  parameter int Speed    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    in_data_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [AccWidth-1:0] out_count_o,
  output logic                out_ovf_o,
  output popcnt_state_e       dbg_state_o
);

  localparam int CntW = cnt_width(Width);

  // Handshake: a beat/total transfers on a rising edge where valid && ready.
  // The whole pipe freezes only while a total is offered and not taken.
  logic stall;
  assign stall       = out_valid_o && !out_ready_i;
  assign in_ready_o  = !stall;

  logic             s1_valid_q, s1_last_q;
  logic [Width-1:0] s1_data_q;
  logic             s2_valid_q, s2_last_q;
  logic [CntW-1:0]  s2_cnt_q;
  logic [CntW-1:0]  s1_cnt;

  popcnt_compress #(.Width(Width), .Speed(Speed)) u_compress (
    .data_i  (s1_data_q),
    .count_o (s1_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_cnt_q   <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid_i;
      s1_last_q  <= in_last_i;
      s1_data_q  <= in_data_i;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_cnt_q   <= s1_cnt;
    end
  end

  popcnt_state_e         state_q, state_d;
  logic [AccWidth-1:0]   acc_q, acc_d, cnt_q, cnt_d;
  logic                  sticky_q, sticky_d, ovf_q, ovf_d;
  logic [AccWidth:0]     sum_full;
  logic                  carry;
  logic [AccWidth-1:0]   sum_res;

  assign sum_full = {1'b0, acc_q} + (AccWidth + 1)'(s2_cnt_q);
  assign carry    = sum_full[AccWidth];
`ifdef POPCNT_SATURATE_EN
  assign sum_res  = carry ? {AccWidth{1'b1}} : sum_full[AccWidth-1:0];
`else
  assign sum_res  = sum_full[AccWidth-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (!stall) begin
      // Not stalled while in DONE means the total was taken this edge.
      if (state_q == DONE) state_d = IDLE;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          cnt_d    = sum_res;
          ovf_d    = sticky_q | carry;
          acc_d    = '0;
          sticky_d = 1'b0;
          state_d  = DONE;
        end else begin
          acc_d    = sum_res;
          sticky_d = sticky_q | carry;
          state_d  = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid_o = (state_q == DONE);
  assign out_count_o = cnt_q;
  assign out_ovf_o   = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_popcnt_stream_acc.sv
// Bench for popcnt_stream_acc: a 16-bit and a 5-bit accumulator driven in
// lockstep, checked by a monitor against a frame-total reference model.
module tb_popcnt_stream_acc;
  import popcnt_pkg::*;

  localparam int W = 23;  // {ovf16, cnt16, ovf5, cnt5}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic in_ready, in_ready5, out_valid, out_valid5, ovf, ovf5;
  logic [15:0] cnt;
  logic [4:0]  cnt5;
  popcnt_state_e st, st5;

  popcnt_stream_acc #(.Width(16), .AccWidth(16), .Speed(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_count_o(cnt), .out_ovf_o(ovf), .dbg_state_o(st)
  );

  popcnt_stream_acc #(.Width(16), .AccWidth(5), .Speed(0)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready5),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid5),
    .out_ready_i(out_ready), .out_count_o(cnt5), .out_ovf_o(ovf5), .dbg_state_o(st5)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int checks = 0, passes = 0;
  int frame_acc = 0;
  int run_len = 0, max_run = 0;
  logic rand_done = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a frame total is just the sum of popcounts of its beats.
  function automatic logic [W-1:0] frame_result(int total);
    logic [15:0] c16;
    logic [4:0]  c5;
    logic        o16, o5;
    o16 = (total > 65535);
    o5  = (total > 31);
`ifdef POPCNT_SATURATE_EN
    c16 = o16 ? 16'hFFFF : 16'(total);
    c5  = o5 ? 5'h1F : 5'(total);
`else
    c16 = 16'(total);
    c5  = 5'(total);
`endif
    return {o16, c16, o5, c5};
  endfunction

  // Driver: entered and left at posedge+1.
  task automatic send_beat(logic [15:0] d, logic l);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
    else begin
      frame_acc += $countones(d);
      if (l) begin
        exp_q.push_back(frame_result(frame_acc));
        frame_acc = 0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
          run_len = 0;
        end else begin
          mon_exp = exp_q[0];
          chk("count16", 32'(cnt), 32'(mon_exp[21:6]));
          chk("ovf16", 32'(ovf), 32'(mon_exp[22]));
          chk("count5", 32'(cnt5), 32'(mon_exp[4:0]));
          chk("ovf5", 32'(ovf5), 32'(mon_exp[5]));
          chk("valid_align5", 32'(out_valid5), 32'd1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            run_len++;
          end else begin
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            chk("in_ready5_stall", 32'(in_ready5), 32'd0);
            run_len = 0;
          end
        end
      end else begin
        run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    int nb;
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_count", 32'(cnt), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_state", 32'(st), 32'(IDLE));
    @(posedge clk);
    #1;

    // Latency of a single-beat frame
    send_beat(16'hFFFF, 1'b1);
    @(negedge clk);
    chk("lat_edge_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Multi-beat frame then a fresh frame
    send_beat(16'h0001, 1'b0);
    send_beat(16'h00FF, 1'b0);
    send_beat(16'hF0F0, 1'b1);
    send_beat(16'h000F, 1'b1);
    wait_drain();

    // Back-pressure across two frames
    out_ready = 1'b0;
    fork
      begin
        send_beat(16'h1234, 1'b0);
        send_beat(16'h8001, 1'b0);
        send_beat(16'h00F0, 1'b1);
        send_beat(16'hFF00, 1'b0);
        send_beat(16'h0003, 1'b1);
      end
      begin
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Overflow in the 5-bit accumulator
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0007, 1'b1);
    wait_drain();

    // Reset mid-frame discards the partial frame
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0F0F, 1'b0);
    rst_n = 1'b0;
    frame_acc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_beat(16'h000F, 1'b1);
    wait_drain();

    // Back-to-back single-beat frames
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      d = 16'h0001 << i;
      send_beat(d, 1'b1);
    end
    wait_drain();
    chk("b2b_run", 32'(max_run), 32'd8);

    // Randomized frames under random back-pressure
    fork
      begin
        for (int f = 0; f < 300; f++) begin
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            send_beat(d, b == nb - 1);
            if ($urandom_range(0, 4) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/popcnt_stream_acc.md
# popcnt_stream_acc

Streaming population-count accumulator that sits downstream of the full-adder counter slices. It accepts one `Width`-bit vector per beat over a valid/ready handshake and compresses each beat to a bit count with the counter-slice tree. It sums the counts across a frame delimited by `in_last_i` and presents one total per frame on a valid/ready output. It is the sequential wrapper that turns the combinational (m,k)-counters into a pipelined, back-pressurable datapath unit.

## Interface
- `Width`, 16: input bits per beat; must be ≥ 4.
- `AccWidth`, 16: accumulator and output width; must be ≥ CntW = $clog2(Width+1).
- `Speed`, 1: compressor structure; 0 = linear full-adder chain, 1 = full-adder tree.

- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset; synchronous, active-low.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: input beat accepted when both valid and ready are high at a rising edge.
- `in_data_i` in Width: bits to count.
- `in_last_i` in 1: beat closes the current frame.
- `out_valid_o` out 1: frame total valid.
- `out_ready_i` in 1: downstream accepts the total.
- `out_count_o` out AccWidth: frame total.
- `out_ovf_o` out 1: accumulator overflowed during this frame.

## Operation
- Three register stages:
  - S1 captures data and last.
  - S2 captures the CntW-bit count from the compressor.
  - S3 holds the accumulator and the output register.
- Stall condition: stall = out_valid_o && !out_ready_i.
  - While stalled, all stage registers, valids and the accumulator hold their values.
  - in_ready_o = !stall, driven combinationally.
- FSM (in `popcnt_pkg`): IDLE (accumulator 0, no frame open), ACCUM (frame open), DONE (output valid, awaiting accept).
  - IDLE→ACCUM: S2 valid with last=0.
  - IDLE/ACCUM→DONE: S2 valid with last=1.
  - DONE→IDLE: handshake, no S2 beat.
  - DONE→ACCUM: handshake plus an S2 beat with last=0.
  - DONE→DONE: handshake plus an S2 beat with last=1. The output register reloads on the same edge.
- Accumulate: acc ← acc + zero-extended count on each non-stalled S2-valid beat.
- Last beat handling: out_count_o ← acc + count, out_ovf_o ← sticky overflow OR'd with this add's overflow. The accumulator and sticky flag then clear to 0.
- A frame may be a single beat. An all-zero data beat still advances the frame.
- Overflow: a carry out of bit AccWidth-1 sets the sticky flag. Default behaviour wraps modulo 2^AccWidth.
- Reset (synchronous, any state, including mid-frame):
  - All valids, the accumulator, the sticky flag and the FSM go to IDLE/0.
  - Any partial frame or pending output is discarded.
  - Reset values: out_valid_o=0, out_count_o=0, out_ovf_o=0. in_ready_o=1 from the first cycle after reset.

## Timing
- Latency: a last beat accepted at edge N gives out_valid_o high after edge N+2.
- Throughput: one beat per cycle. Back-to-back single-beat frames produce one total per cycle when out_ready_i is held at 1.
- in_ready_o falls in the same cycle that out_valid_o=1 and out_ready_i=0. No beat is lost or duplicated.
- out_count_o and out_ovf_o are stable while out_valid_o=1 and out_ready_i=0.
- No combinational path from in_valid_i to out_valid_o. out_ready_i reaches in_ready_o combinationally.

## Configuration
- `POPCNT_SATURATE_EN`:
  - Defined: the accumulator clamps at 2^AccWidth−1 on overflow and stays there until the frame ends. out_ovf_o is still set.
  - Undefined: the accumulator wraps modulo 2^AccWidth and out_ovf_o flags the wrap.

## Structure
- `popcnt_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, DONE);
  - a `cnt_width(Width)` constant function returning $clog2(Width+1).
- Sub-module `popcnt_compress`: purely combinational. It takes Width bits in, builds the count out of counter slices and full adders with the `Speed` selection, and outputs CntW bits. It sits between S1 and S2.

## Test plan
- Width=16, single beat 0xFFFF with last=1 accepted at edge N → out_valid_o after N+2, out_count_o=16, out_ovf_o=0.
- Frame of 0x0001, 0x00FF, 0xF0F0 (last on the third beat) → out_count_o=17. A following frame starts from 0.
- Two frames streamed with out_ready_i=0 for 5 cycles while the first total is valid → in_ready_o=0 during the stall, total held stable, second frame total correct, no beats lost.
- AccWidth=5, frame 0xFFFF, 0xFFFF, 0x0007 → without macro: count 3, ovf=1. With `POPCNT_SATURATE_EN`: count 31, ovf=1.
- Two beats without last, rst_ni=0 for 1 cycle, then 0x000F with last → out_count_o=4. Nothing is emitted for the discarded frame.
- Eight consecutive single-beat frames 0x0001..0x0080 (each with last=1) with out_ready_i=1 → eight totals of 1 on consecutive cycles.
